// File: rtl/fp_multiplier_pipe.sv
// Three-stage IEEE-754 multiplier (unpack/classify, multiply, normalise/round/pack).
// Valid/ready handshake per stage; round-to-nearest-even, subnormals flushed to zero.
module fp_multiplier_pipe #(
    parameter int unsigned N       = 32,
    parameter int unsigned OUT_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Result,
    output logic [3:0]   flags
);
    localparam int unsigned E = (N == 64) ? 11 : 8;
    localparam int unsigned M = (N == 64) ? 52 : 23;
    localparam logic [E+1:0]        BIAS     = (E+2)'((1 << (E - 1)) - 1);
    localparam logic signed [E+1:0] EXP_MAX  = (E+2)'((1 << E) - 1);
    localparam logic signed [E+1:0] EXP_ZERO = '0;

    logic          rdy_q;
    logic          v1_q, v1_d, v2_q, v2_d;
    logic          adv1, adv2, accept;

    logic          s1_sign_q, s1_sign_d;
    logic [E-1:0]  s1_ea_q, s1_ea_d, s1_eb_q, s1_eb_d;
    logic [M:0]    s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
    logic [3:0]    s1_cls_q, s1_cls_d;  // {nan, inf, zero, invalid}

    logic                  s2_sign_q, s2_sign_d;
    logic signed [E+1:0]   s2_exp_q, s2_exp_d;
    logic [2*M+1:0]        s2_prod_q, s2_prod_d;
    logic [3:0]            s2_cls_q, s2_cls_d;

    logic          sa, sb;
    logic [E-1:0]  ea, eb;
    logic [M-1:0]  ma, mb;
    logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic          nan_c, inf_c, zero_c, inv_c;

    logic [2*M+1:0]      prod;
    logic [E+1:0]        exp_sum;

    logic                norm, guard, sticky, round_up;
    logic [2*M:0]        prod_n;
    logic [M-1:0]        mant;
    logic [M:0]          mant_r;
    logic signed [E+1:0] exp_r;
    logic [N-1:0]        res_c;
    logic [3:0]          flg_c;

    always_comb begin
        {sa, ea, ma} = A;
        {sb, eb, mb} = B;
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (ma == '0);
        b_inf  = (eb == '1) && (mb == '0);
        a_nan  = (ea == '1) && (ma != '0);
        b_nan  = (eb == '1) && (mb != '0);
        nan_c  = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
        inf_c  = (a_inf | b_inf) & ~nan_c;
        zero_c = (a_zero | b_zero) & ~nan_c & ~inf_c;
        inv_c  = (a_zero & b_inf) | (a_inf & b_zero) | (a_nan & ~ma[M-1]) | (b_nan & ~mb[M-1]);
    end

    assign prod    = {{(M+1){1'b0}}, s1_ma_q} * {{(M+1){1'b0}}, s1_mb_q};
    assign exp_sum = {2'b00, s1_ea_q} + {2'b00, s1_eb_q} - BIAS;

    // Handshake: a stage loads when the next one is empty or draining this cycle.
    always_comb begin
        adv1     = v1_q & (~v2_q | adv2);
        in_ready = rdy_q & (~v1_q | adv1);
        accept   = in_valid & in_ready;
        v1_d     = accept | (v1_q & ~adv1);
        v2_d     = adv1 | (v2_q & ~adv2);

        s1_sign_d = s1_sign_q;
        s1_ea_d   = s1_ea_q;
        s1_eb_d   = s1_eb_q;
        s1_ma_d   = s1_ma_q;
        s1_mb_d   = s1_mb_q;
        s1_cls_d  = s1_cls_q;
        if (accept) begin
            s1_sign_d = sa ^ sb;
            s1_ea_d   = ea;
            s1_eb_d   = eb;
            s1_ma_d   = {1'b1, ma};
            s1_mb_d   = {1'b1, mb};
            s1_cls_d  = {nan_c, inf_c, zero_c, inv_c};
        end

        s2_sign_d = s2_sign_q;
        s2_exp_d  = s2_exp_q;
        s2_prod_d = s2_prod_q;
        s2_cls_d  = s2_cls_q;
        if (adv1) begin
            s2_sign_d = s1_sign_q;
            s2_exp_d  = exp_sum;
            s2_prod_d = prod;
            s2_cls_d  = s1_cls_q;
        end
    end

    always_comb begin
        norm     = s2_prod_q[2*M+1];
        prod_n   = norm ? s2_prod_q[2*M:0] : {s2_prod_q[2*M-1:0], 1'b0};
        mant     = prod_n[2*M:M+1];
        guard    = prod_n[M];
        sticky   = |prod_n[M-1:0];
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + {{M{1'b0}}, round_up};
        // A rounding carry leaves mant_r[M-1:0] at zero and bumps the exponent.
        exp_r    = s2_exp_q + {{(E+1){1'b0}}, norm} + {{(E+1){1'b0}}, mant_r[M]};
        res_c    = {s2_sign_q, exp_r[E-1:0], mant_r[M-1:0]};
        flg_c    = {3'b000, guard | sticky};
        if (exp_r >= EXP_MAX) begin
            res_c = {s2_sign_q, {E{1'b1}}, {M{1'b0}}};
            flg_c = 4'b0101;
        end else if (exp_r <= EXP_ZERO) begin
            res_c = {s2_sign_q, {(N-1){1'b0}}};
            flg_c = 4'b0011;
        end
        if (s2_cls_q[3]) begin
            res_c = {1'b0, {(N-1){1'b1}}};
            flg_c = {s2_cls_q[0], 3'b000};
        end else if (s2_cls_q[2]) begin
            res_c = {s2_sign_q, {E{1'b1}}, {M{1'b0}}};
            flg_c = 4'b0000;
        end else if (s2_cls_q[1]) begin
            res_c = {s2_sign_q, {(N-1){1'b0}}};
            flg_c = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_ea_q   <= '0;
            s1_eb_q   <= '0;
            s1_ma_q   <= '0;
            s1_mb_q   <= '0;
            s1_cls_q  <= '0;
            s2_sign_q <= 1'b0;
            s2_exp_q  <= '0;
            s2_prod_q <= '0;
            s2_cls_q  <= '0;
        end else begin
            rdy_q     <= 1'b1;  // ready comes up one edge after reset release
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            s1_sign_q <= s1_sign_d;
            s1_ea_q   <= s1_ea_d;
            s1_eb_q   <= s1_eb_d;
            s1_ma_q   <= s1_ma_d;
            s1_mb_q   <= s1_mb_d;
            s1_cls_q  <= s1_cls_d;
            s2_sign_q <= s2_sign_d;
            s2_exp_q  <= s2_exp_d;
            s2_prod_q <= s2_prod_d;
            s2_cls_q  <= s2_cls_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic         v3_q, v3_d;
        logic [N-1:0] res_q, res_d;
        logic [3:0]   flg_q, flg_d;

        assign adv2 = v2_q & (~v3_q | out_ready);

        always_comb begin
            v3_d  = adv2 | (v3_q & ~out_ready);
            res_d = adv2 ? res_c : res_q;
            flg_d = adv2 ? flg_c : flg_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v3_q  <= 1'b0;
                res_q <= '0;
                flg_q <= '0;
            end else begin
                v3_q  <= v3_d;
                res_q <= res_d;
                flg_q <= flg_d;
            end
        end

        assign out_valid = v3_q;
        assign Result    = res_q;
        assign flags     = flg_q;
    end else begin : g_out_comb
        assign adv2      = v2_q & out_ready;
        assign out_valid = v2_q;
        assign Result    = v2_q ? res_c : '0;
        assign flags     = v2_q ? flg_c : '0;
    end

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Directed bench for fp_multiplier_pipe: single-precision and double-precision instances.
module tb_fp_multiplier_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] a32, b32, res32;
    logic [3:0]  flags32;
    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [63:0] a64, b64, res64;
    logic [3:0]  flags64;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_multiplier_pipe #(.N(32), .OUT_REG(1)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .A         (a32),
        .B         (b32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .Result    (res32),
        .flags     (flags32)
    );

    fp_multiplier_pipe #(.N(64), .OUT_REG(1)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .A         (a64),
        .B         (b64),
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .Result    (res64),
        .flags     (flags64)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t vt [15] = '{
        '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000},
        '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001},
        '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101},
        '{32'h00000000, 32'hFF800000, 32'h7FFFFFFF, 4'b1000},
        '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000},
        '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011},
        '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000},
        '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'b0001},
        '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001},
        '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001},
        '{32'hC0000000, 32'hC0400000, 32'h40C00000, 4'b0000},
        '{32'h7F800001, 32'h3F800000, 32'h7FFFFFFF, 4'b1000},
        '{32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF, 4'b0000},
        '{32'h80000001, 32'h40000000, 32'h80000000, 4'b0000},
        '{32'hFF800000, 32'h00000000, 32'h7FFFFFFF, 4'b1000}
    };

    logic [31:0] va [5] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40000000, 32'h3F000000};
    logic [31:0] vb [5] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] vr [5] = '{32'h3F800000, 32'h40800000, 32'h40400000, 32'h40C00000, 32'h40000000};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers one pair, waits for the result with out_ready held high.
    task automatic run_vec(input bit w64, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_res, input logic [3:0] exp_fl,
                           input string tag);
        int   lat;
        logic ov;
        @(posedge clk); #1;
        if (w64) begin
            in_valid64 = 1'b1; a64 = a; b64 = b;
        end else begin
            in_valid32 = 1'b1; a32 = a[31:0]; b32 = b[31:0];
        end
        @(negedge clk);
        check_eq({tag, "_rdy"}, 64'(w64 ? in_ready64 : in_ready32), 64'd1);
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
        lat = 0;
        ov  = 1'b0;
        while (!ov && lat < 10) begin
            @(negedge clk);
            lat++;
            ov = w64 ? out_valid64 : out_valid32;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'd3);
        check_eq({tag, "_res"}, w64 ? res64 : 64'(res32), exp_res);
        check_eq({tag, "_flg"}, 64'(w64 ? flags64 : flags32), 64'(exp_fl));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          idx, nout, ovc;
        logic [35:0] held;
        bit          have_held;

        rst_n = 1'b0;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; out_ready32 = 1'b1;
        in_valid64 = 1'b0; a64 = '0; b64 = '0; out_ready64 = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready32", 64'(in_ready32), 64'd0);
        check_eq("rst_in_ready64", 64'(in_ready64), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid32), 64'd0);
        check_eq("rst_result", 64'(res32), 64'd0);
        check_eq("rst_flags", 64'(flags32), 64'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_ready_before_edge", 64'(in_ready32), 64'd0);
        @(posedge clk); #1;
        check_eq("rel_ready_after_edge", 64'(in_ready32), 64'd1);

        for (int i = 0; i < 15; i++)
            run_vec(1'b0, 64'(vt[i].a), 64'(vt[i].b), 64'(vt[i].r), vt[i].f,
                    $sformatf("v%0d", i));

        // Stall: 6 cycles of out_ready low while five pairs are offered.
        @(posedge clk); #1;
        out_ready32 = 1'b0;
        idx = 0;
        have_held = 1'b0;
        held = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            in_valid32 = (idx < 5);
            if (idx < 5) begin a32 = va[idx]; b32 = vb[idx]; end
            @(negedge clk);
            if (out_valid32) begin
                if (!have_held) begin
                    held = {flags32, res32};
                    have_held = 1'b1;
                end else begin
                    check_eq($sformatf("stall_hold%0d", c), 64'({flags32, res32}), 64'(held));
                end
            end
            if (in_valid32 && in_ready32) idx++;
        end
        check_eq("stall_accepts", 64'(idx), 64'd3);
        check_eq("stall_ready_low", 64'(in_ready32), 64'd0);
        check_eq("stall_out_valid", 64'(out_valid32), 64'd1);

        nout = 0;
        for (int c = 0; c < 30 && nout < 5; c++) begin
            @(posedge clk); #1;
            out_ready32 = 1'b1;
            in_valid32 = (idx < 5);
            if (idx < 5) begin a32 = va[idx]; b32 = vb[idx]; end
            @(negedge clk);
            if (out_valid32) begin
                check_eq($sformatf("drain%0d", nout), 64'(res32), 64'(vr[nout]));
                nout++;
            end
            if (in_valid32 && in_ready32) idx++;
        end
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        check_eq("drain_count", 64'(nout), 64'd5);
        ovc = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid32) ovc++;
        end
        check_eq("drain_no_extra", 64'(ovc), 64'd0);

        run_vec(1'b1, 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000,
                4'b0000, "d0");

        // Two operands in flight, then reset.
        @(posedge clk); #1;
        in_valid64 = 1'b1; a64 = 64'h4000000000000000; b64 = 64'h4000000000000000;
        @(posedge clk); #1;
        a64 = 64'h3FF0000000000000;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", 64'(out_valid64), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready64), 64'd0);
        rst_n = 1'b1;
        ovc = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid64) ovc++;
        end
        check_eq("midrst_flushed", 64'(ovc), 64'd0);

        run_vec(1'b1, 64'hC000000000000000, 64'h4000000000000000, 64'hC010000000000000,
                4'b0000, "d1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
